// File: rtl/l2_stream_buffer.sv
// Dual-width stream buffer between a narrow L1 port and a wide DDR port.
// Storage is RATIO narrow-wide banks; a wide word spans one row of all banks.
module l2_stream_buffer #(
  parameter int NARROW_W   = 16,
  parameter int RATIO      = 8,
  parameter int DEPTH_LOG2 = 12,
  parameter int AFULL_THR  = 4032
) (
  input  logic                        clk_166M66,
  input  logic                        i_rst,
  input  logic                        i_mode,
  input  logic                        i_flush,
  input  logic                        i_l1_req,
  input  logic [NARROW_W-1:0]         i_l1_wdata,
  output logic                        o_l1_ack,
  output logic                        o_l1_rvalid,
  output logic [NARROW_W-1:0]         o_l1_rdata,
  input  logic                        i_ddr_req,
  input  logic [NARROW_W*RATIO-1:0]   i_ddr_wdata,
  output logic                        o_ddr_ack,
  output logic                        o_ddr_rvalid,
  output logic [NARROW_W*RATIO-1:0]   o_ddr_rdata,
  output logic                        o_mode,
  output logic [DEPTH_LOG2:0]         o_level,
  output logic                        o_empty,
  output logic                        o_full,
  output logic                        o_afull
);

  localparam int RLOG   = $clog2(RATIO);
  localparam int WLOG   = DEPTH_LOG2 - RLOG;
  localparam int WDEPTH = 1 << WLOG;
  localparam int LW     = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] DEPTH_L = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [LW-1:0] RATIO_L = LW'(RATIO);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_THR);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} mode_e;

  logic [DEPTH_LOG2-1:0]              nptr_q;
  logic [WLOG-1:0]                    wptr_q;
  logic [LW-1:0]                      level_q, level_d, free;
  mode_e                              mode_q;
  logic                               l1_rvalid_q, ddr_rvalid_q;
  logic [NARROW_W-1:0]                l1_rdata_q;
  logic [RATIO-1:0][NARROW_W-1:0]     ddr_rdata_q, rd_lanes;
  logic                               l1_ack, ddr_ack, mode_sw, blk;
  logic [RLOG-1:0]                    nlane;
  logic [WLOG-1:0]                    nrow;

  assign nlane   = nptr_q[RLOG-1:0];
  assign nrow    = nptr_q[DEPTH_LOG2-1:RLOG];
  assign free    = DEPTH_L - level_q;
  // A mode change is only taken on an empty buffer and steals that cycle.
  assign mode_sw = (level_q == '0) && (i_mode != mode_q);
  assign blk     = i_rst || i_flush || mode_sw;

  always_comb begin
    l1_ack  = 1'b0;
    ddr_ack = 1'b0;
    if (!blk) begin
      if (mode_q == FILL) begin
        ddr_ack = i_ddr_req && (free >= RATIO_L);
        l1_ack  = i_l1_req && (level_q != '0);
      end else begin
        l1_ack  = i_l1_req && (level_q < DEPTH_L);
        ddr_ack = i_ddr_req && (level_q >= RATIO_L);
      end
    end
  end

  always_comb begin
    level_d = level_q;
    if (mode_q == FILL) begin
      if (ddr_ack) level_d = level_d + RATIO_L;
      if (l1_ack)  level_d = level_d - LW'(1);
    end else begin
      if (l1_ack)  level_d = level_d + LW'(1);
      if (ddr_ack) level_d = level_d - RATIO_L;
    end
  end

  for (genvar k = 0; k < RATIO; k++) begin : g_bank
    logic [NARROW_W-1:0] mem [WDEPTH];
    logic                we;
    logic [WLOG-1:0]     waddr, raddr;
    logic [NARROW_W-1:0] wdat;

    // Fill writes whole rows from DDR; drain writes one lane from L1.
    assign we    = (mode_q == FILL) ? ddr_ack : (l1_ack && (nlane == RLOG'(k)));
    assign waddr = (mode_q == FILL) ? wptr_q : nrow;
    assign wdat  = (mode_q == FILL) ? i_ddr_wdata[k*NARROW_W +: NARROW_W] : i_l1_wdata;
    assign raddr = (mode_q == FILL) ? nrow : wptr_q;

    always_ff @(posedge clk_166M66) begin
      if (we) mem[waddr] <= wdat;
    end

    assign rd_lanes[k] = mem[raddr];
  end

  always_ff @(posedge clk_166M66) begin
    if (i_rst || i_flush) begin
      nptr_q       <= '0;
      wptr_q       <= '0;
      level_q      <= '0;
      l1_rvalid_q  <= 1'b0;
      ddr_rvalid_q <= 1'b0;
      l1_rdata_q   <= '0;
      ddr_rdata_q  <= '0;
      if (i_rst) mode_q <= FILL;
    end else begin
      if (mode_sw) mode_q <= mode_e'(i_mode);
      nptr_q       <= nptr_q + DEPTH_LOG2'(l1_ack);
      wptr_q       <= wptr_q + WLOG'(ddr_ack);
      level_q      <= level_d;
      l1_rvalid_q  <= l1_ack && (mode_q == FILL);
      ddr_rvalid_q <= ddr_ack && (mode_q == DRAIN);
      if (l1_ack && (mode_q == FILL))   l1_rdata_q  <= rd_lanes[nlane];
      if (ddr_ack && (mode_q == DRAIN)) ddr_rdata_q <= rd_lanes;
    end
  end

  assign o_l1_ack     = l1_ack;
  assign o_ddr_ack    = ddr_ack;
  assign o_l1_rvalid  = l1_rvalid_q;
  assign o_l1_rdata   = l1_rdata_q;
  assign o_ddr_rvalid = ddr_rvalid_q;
  assign o_ddr_rdata  = ddr_rdata_q;
  assign o_mode       = mode_q;
  assign o_level      = level_q;
  assign o_empty      = (level_q == '0);
  assign o_full       = (level_q == DEPTH_L);
  assign o_afull      = (level_q >= AFULL_L);

endmodule

// File: tb/tb_l2_stream_buffer.sv
// Scoreboard bench for l2_stream_buffer: a narrow-word FIFO model predicts acks,
// level, flags and read data.
module tb_l2_stream_buffer;
  localparam int NW = 16, R = 8, DL = 12, DEPTH = 4096, AF = 4032, WW = NW*R;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1, i_mode = 1'b0, i_flush = 1'b0;
  logic          i_l1_req = 1'b0, i_ddr_req = 1'b0;
  logic [NW-1:0] i_l1_wdata = '0;
  logic [WW-1:0] i_ddr_wdata = '0;
  logic          o_l1_ack, o_l1_rvalid, o_ddr_ack, o_ddr_rvalid, o_mode;
  logic [NW-1:0] o_l1_rdata;
  logic [WW-1:0] o_ddr_rdata;
  logic [DL:0]   o_level;
  logic          o_empty, o_full, o_afull;

  always #3 clk = ~clk;

  l2_stream_buffer #(.NARROW_W(NW), .RATIO(R), .DEPTH_LOG2(DL), .AFULL_THR(AF)) dut (
    .clk_166M66(clk), .i_rst(i_rst), .i_mode(i_mode), .i_flush(i_flush),
    .i_l1_req(i_l1_req), .i_l1_wdata(i_l1_wdata), .o_l1_ack(o_l1_ack),
    .o_l1_rvalid(o_l1_rvalid), .o_l1_rdata(o_l1_rdata),
    .i_ddr_req(i_ddr_req), .i_ddr_wdata(i_ddr_wdata), .o_ddr_ack(o_ddr_ack),
    .o_ddr_rvalid(o_ddr_rvalid), .o_ddr_rdata(o_ddr_rdata),
    .o_mode(o_mode), .o_level(o_level), .o_empty(o_empty), .o_full(o_full),
    .o_afull(o_afull));

  int            nvec = 0, nerr = 0;
  logic [NW-1:0] mq[$];
  logic [NW-1:0] l1q[$];
  logic [WW-1:0] ddrq[$];
  logic          mode_m = 1'b0;
  logic          e_l1, e_ddr, ev_l1, ev_ddr;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int lvl;
    logic blk;
    logic [WW-1:0] w;
    @(negedge clk);
    lvl = mq.size();
    blk = i_rst || i_flush || (lvl == 0 && i_mode != mode_m);
    if (!mode_m) begin
      e_ddr = i_ddr_req && !blk && (DEPTH - lvl) >= R;
      e_l1  = i_l1_req && !blk && lvl >= 1;
    end else begin
      e_l1  = i_l1_req && !blk && lvl < DEPTH;
      e_ddr = i_ddr_req && !blk && lvl >= R;
    end
    chk("l1_ack", WW'(o_l1_ack), WW'(e_l1));
    chk("ddr_ack", WW'(o_ddr_ack), WW'(e_ddr));
    ev_l1 = 1'b0;
    ev_ddr = 1'b0;
    if (!mode_m) begin
      if (e_l1) begin l1q.push_back(mq.pop_front()); ev_l1 = 1'b1; end
      if (e_ddr) for (int k = 0; k < R; k++) mq.push_back(i_ddr_wdata[k*NW +: NW]);
    end else begin
      if (e_ddr) begin
        w = '0;
        for (int k = 0; k < R; k++) w[k*NW +: NW] = mq.pop_front();
        ddrq.push_back(w);
        ev_ddr = 1'b1;
      end
      if (e_l1) mq.push_back(i_l1_wdata);
    end
    if (i_rst) begin mq.delete(); mode_m = 1'b0; end
    else if (i_flush) mq.delete();
    else if (lvl == 0 && i_mode != mode_m) mode_m = i_mode;
    @(posedge clk);
    #1;
    chk("l1_rvalid", WW'(o_l1_rvalid), WW'(ev_l1));
    if (ev_l1 && l1q.size() > 0) chk("l1_rdata", WW'(o_l1_rdata), WW'(l1q.pop_front()));
    chk("ddr_rvalid", WW'(o_ddr_rvalid), WW'(ev_ddr));
    if (ev_ddr && ddrq.size() > 0) chk("ddr_rdata", o_ddr_rdata, ddrq.pop_front());
    chk("level", WW'(o_level), WW'(mq.size()));
    chk("flags", WW'({o_empty, o_full, o_afull}),
        WW'({mq.size() == 0, mq.size() == DEPTH, mq.size() >= AF}));
    chk("mode", WW'(o_mode), WW'(mode_m));
  endtask

  task automatic idle();
    i_l1_req = 1'b0; i_ddr_req = 1'b0; i_flush = 1'b0; i_rst = 1'b0;
  endtask

  task automatic rnd_wide();
    for (int k = 0; k < R; k++) i_ddr_wdata[k*NW +: NW] = NW'($urandom);
  endtask

  initial begin
    int sent;
    // reset, then an L1 read on an empty fill buffer
    i_rst = 1'b1;
    step(); step();
    idle();
    chk("rst_l1_rdata", WW'(o_l1_rdata), '0);
    chk("rst_ddr_rdata", o_ddr_rdata, '0);
    i_l1_req = 1'b1;
    step();
    idle();

    // fill ordering: lanes 0..7 hold 0,2,..,E
    for (int k = 0; k < R; k++) i_ddr_wdata[k*NW +: NW] = NW'(2*k);
    i_ddr_req = 1'b1;
    step();
    idle();
    i_l1_req = 1'b1;
    for (int i = 0; i < R; i++) step();
    idle();

    // fill to full, overflow attempts, then simultaneous at 4088
    i_ddr_req = 1'b1;
    for (int i = 0; i < 512; i++) begin rnd_wide(); step(); end
    chk("full_level", WW'(o_level), WW'(4096));
    rnd_wide(); step();
    idle(); i_l1_req = 1'b1; step();
    idle(); i_ddr_req = 1'b1; rnd_wide(); step();
    idle(); i_l1_req = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("lvl_4088", WW'(o_level), WW'(4088));
    i_ddr_req = 1'b1; rnd_wide(); step();
    chk("sim_fill_lvl", WW'(o_level), WW'(4095));
    idle(); i_l1_req = 1'b1;
    for (int c = 0; c < 5000 && mq.size() > 0; c++) step();
    idle();
    chk("fill_drained", WW'(o_level), '0);

    // flush at level 100 with a pending L1 read
    i_ddr_req = 1'b1;
    for (int i = 0; i < 13; i++) begin rnd_wide(); step(); end
    idle(); i_l1_req = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("lvl_100", WW'(o_level), WW'(100));
    i_flush = 1'b1;
    step();
    idle();
    chk("flush_lvl", WW'(o_level), '0);

    // switch to drain: switch cycle grants nothing
    i_mode = 1'b1; i_l1_req = 1'b1; i_ddr_req = 1'b1; i_l1_wdata = 16'hBEEF;
    step();
    chk("sw_mode", WW'(o_mode), WW'(1));
    idle(); i_l1_req = 1'b1;
    for (int i = 0; i < 7; i++) begin i_l1_wdata = NW'(16'h100 + i); step(); end
    idle(); i_ddr_req = 1'b1; step();
    idle(); i_l1_req = 1'b1; i_l1_wdata = 16'h107; step();
    idle(); i_ddr_req = 1'b1; step();
    idle();

    // stream 4100 words to wrap both pointers
    sent = 0;
    i_ddr_req = 1'b1;
    for (int c = 0; c < 6000 && (sent < 4100 || mq.size() >= R); c++) begin
      i_l1_req = (sent < 4100);
      i_l1_wdata = NW'($urandom);
      step();
      if (e_l1) sent++;
    end
    idle();
    chk("stream_sent", WW'(sent), WW'(4100));

    // drain simultaneous at level 10
    i_l1_req = 1'b1;
    for (int c = 0; c < 20 && mq.size() < 10; c++) begin i_l1_wdata = NW'($urandom); step(); end
    chk("lvl_10", WW'(o_level), WW'(10));
    i_ddr_req = 1'b1; i_l1_wdata = NW'($urandom); step();
    chk("sim_drain_lvl", WW'(o_level), WW'(3));
    idle();

    // reset mid-stream at level 20 with a DDR read requested
    i_l1_req = 1'b1;
    for (int c = 0; c < 40 && mq.size() < 20; c++) begin i_l1_wdata = NW'($urandom); step(); end
    idle();
    chk("lvl_20", WW'(o_level), WW'(20));
    i_rst = 1'b1; i_ddr_req = 1'b1;
    step();
    idle();
    chk("rst_rvalid", WW'(o_ddr_rvalid), '0);
    chk("rst_mode", WW'(o_mode), '0);
    chk("rst_ddr_rdata2", o_ddr_rdata, '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
